outport_display_sequencer: RTL
==============================

// Module: outport_display_sequencer
// PURPOSE
//  Sits between the CPU output-port write path and the seven-segment encoder.
//  Buffers bytes written to the output port in a small FIFO and presents each
//  one on disp_data for a fixed hold time, so every write stays visible on the board.
//  disp_data drives the encoder's 8-bit OutPortdata input directly.
// PARAMETERS
//  HOLD_CYCLES  25_000_000  clocks each value is held (0.5 s @ 50 MHz); legal range >= 2
//  CNT_W        25          hold-counter width; must satisfy 2**CNT_W > HOLD_CYCLES
//  DEPTH        4           FIFO entries; power of 2, >= 2
//  RESET_CODE   8'h00       disp_data after reset (encoder shows its error pattern)
// PORTS
//  clock         in   1  system clock, all state on rising edge
//  clear         in   1  synchronous active-high reset
//  wr_en         in   1  output-port write strobe, one byte per asserted cycle
//  wr_data       in   8  byte written to output port
//  disp_data     out  8  value currently displayed (to encoder OutPortdata)
//  disp_new      out  1  1-cycle pulse on the cycle disp_data takes a new FIFO value
//  busy          out  1  1 while in SHOW
//  full          out  1  FIFO holds DEPTH entries
//  overflow      out  1  sticky: a write was dropped
// BEHAVIOUR
//  Reset: on a clock edge with clear=1:
//  - FIFO empties, state goes to IDLE, hold counter goes to 0.
//  - disp_data=RESET_CODE; disp_new=0, busy=0, full=0, overflow=0.
//  - clear overrides every other input on that edge.
//  FIFO: circular buffer with pointer wrap at DEPTH; count from 0 to DEPTH.
//  - write at edge when wr_en && (!full || pop on the same cycle).
//  - wr_en && full && no pop: byte dropped, overflow<=1. overflow clears only on clear.
//  - Simultaneous push+pop: count unchanged, both take effect. When full with a pop,
//    the write is accepted.
//  - pop is internal; it occurs only on the FSM load events below.
//  FSM states IDLE, SHOW:
//  - IDLE, FIFO non-empty: pop head, disp_data<=head, counter<=0, disp_new<=1,
//    go to SHOW.
//  - IDLE, FIFO empty: hold disp_data (last value persists indefinitely).
//  - SHOW, counter < HOLD_CYCLES-1: counter increments.
//  - SHOW, counter == HOLD_CYCLES-1, FIFO non-empty: pop and reload back-to-back,
//    counter<=0, disp_new<=1, stay in SHOW.
//  - SHOW, counter == HOLD_CYCLES-1, FIFO empty: go to IDLE, disp_data unchanged.
//  - Each value is shown for exactly HOLD_CYCLES clocks before the next replaces it.
//  Latency: wr_en at edge N into an empty FIFO in IDLE:
//  - FIFO is written at edge N.
//  - disp_data and disp_new=1 appear after edge N+1.
//  - A push at the same edge as an empty-FIFO pop check is not visible until the
//    next cycle (no bypass).
//  Registered outputs: disp_data and disp_new are registered; full and busy are
//  decoded from registered state.
//  Ordering: values are displayed strictly in write order; no value is skipped
//  unless it was dropped on overflow.
// TESTING
//  (HOLD_CYCLES=8, DEPTH=4 for sim)
//  - Reset: clear for 2 cycles -> disp_data=8'h00, busy=0, full=0, overflow=0,
//    disp_new=0.
//  - Single write 8'h80 in IDLE at edge N -> disp_data=8'h80 and disp_new pulse
//    after N+1; busy for 8 cycles, then IDLE with disp_data still 8'h80.
//  - Burst 8'h01,02,04,08 on consecutive cycles -> shown in order.
//    - Each is held exactly 8 cycles.
//    - disp_new pulses 8 cycles apart.
//    - overflow stays 0.
//  - Burst of 6 writes while the SHOW hold is mid-count -> FIFO full after 4 queued;
//    later writes are dropped; overflow=1 and stays 1 until clear.
//  - Write on the same cycle as the hold-expiry pop with FIFO full -> write accepted,
//    full stays 1, overflow stays 0.
//  - Assert clear mid-SHOW with 3 entries queued -> next cycle disp_data=8'h00,
//    FIFO empty, busy=0; no queued value appears afterwards.

Source files
------------

// File: rtl/outport_display_sequencer.sv
// Output-port display sequencer: queues CPU output-port writes in a small FIFO and
// presents each byte on disp_data for HOLD_CYCLES clocks, in write order.
module outport_display_sequencer #(
  parameter int unsigned HOLD_CYCLES = 25_000_000,
  parameter int unsigned CNT_W       = 25,
  parameter int unsigned DEPTH       = 4,
  parameter logic [7:0]  RESET_CODE  = 8'h00
) (
  input  logic       clock,
  input  logic       clear,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  output logic [7:0] disp_data,
  output logic       disp_new,
  output logic       busy,
  output logic       full,
  output logic       overflow
);
  localparam int unsigned AW = $clog2(DEPTH);

  typedef enum logic {IDLE, SHOW} state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [7:0]       mem [DEPTH];
  logic [AW-1:0]    rd_ptr_reg, wr_ptr_reg;
  logic [AW:0]      count_reg;
  logic [7:0]       disp_data_reg;
  logic             disp_new_reg, overflow_reg;
  logic             pop, push, empty, expire;

  assign empty     = (count_reg == '0);
  assign full      = (count_reg == (AW+1)'(DEPTH));
  assign busy      = (state_reg == SHOW);
  assign expire    = (cnt_reg == CNT_W'(HOLD_CYCLES - 1));
  // A full FIFO still accepts a write on a pop cycle: the popped slot is reused.
  assign push      = wr_en && (!full || pop);
  assign disp_data = disp_data_reg;
  assign disp_new  = disp_new_reg;
  assign overflow  = overflow_reg;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    pop        = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!empty) begin
          pop        = 1'b1;
          cnt_next   = '0;
          state_next = SHOW;
        end
      end
      SHOW: begin
        if (!expire) begin
          cnt_next = cnt_reg + 1'b1;
        end else if (!empty) begin
          pop      = 1'b1;
          cnt_next = '0;
        end else begin
          cnt_next   = '0;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Storage has no reset; validity is tracked entirely by count_reg.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr_reg] <= wr_data;
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      rd_ptr_reg    <= '0;
      wr_ptr_reg    <= '0;
      count_reg     <= '0;
      disp_data_reg <= RESET_CODE;
      disp_new_reg  <= 1'b0;
      overflow_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      disp_new_reg <= pop;
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop) begin
        rd_ptr_reg    <= rd_ptr_reg + 1'b1;
        disp_data_reg <= mem[rd_ptr_reg];
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
      if (wr_en && !push) overflow_reg <= 1'b1;
    end
  end
endmodule
